// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state encoding, ALU op codes and MIPS opcode/func constants
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_R     = 4'd7,
    S_WB_I     = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_ADDU = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SUB  = 4'b1010;
  localparam logic [3:0] ALU_SUBU = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  localparam logic [3:0] ALU_LUI  = 4'b1101;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  // States that wait on mem_ready and therefore run the timeout counter
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational func/opcode to ALU operation decode
module alu_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output logic [3:0] r_op,
  output logic       r_legal,
  output logic [3:0] i_op,
  output logic       i_legal
);

  always_comb begin
    r_op    = ALU_NOP;
    r_legal = 1'b1;
    case (func)
      FN_ADD:  r_op = ALU_ADD;
      FN_ADDU: r_op = ALU_ADDU;
      FN_AND:  r_op = ALU_AND;
      FN_OR:   r_op = ALU_OR;
      FN_NOR:  r_op = ALU_NOR;
      FN_SLTU: r_op = ALU_SLTU;
      FN_SLT:  r_op = ALU_SLT;
      FN_SLL:  r_op = ALU_SLL;
      FN_SRL:  r_op = ALU_SRL;
      FN_SUB:  r_op = ALU_SUB;
      FN_SUBU: r_op = ALU_SUBU;
      FN_SRA:  r_op = ALU_SRA;
      default: r_legal = 1'b0;
    endcase
  end

  always_comb begin
    i_op    = ALU_NOP;
    i_legal = 1'b1;
    case (opcode)
      OP_ADDI:  i_op = ALU_ADD;
      OP_ADDIU: i_op = ALU_ADDU;
      OP_ANDI:  i_op = ALU_AND;
      OP_ORI:   i_op = ALU_OR;
      OP_SLTI:  i_op = ALU_SLT;
      OP_SLTIU: i_op = ALU_SLTU;
      OP_LUI:   i_op = ALU_LUI;
      default:  i_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM with memory wait timeout and sticky trap
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 4,
  parameter int MEM_WAIT_EN = 1,
  parameter int TIMEOUT     = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic               link,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal,
  output logic [3:0]         state
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic             illegal_q;
  logic [3:0]       r_op, i_op, op4;
  logic             r_legal, i_legal;
  logic             mem_done, mem_wait, timeout_hit;
  logic             is_jr, is_jal;

  alu_op_decode u_alu_op_decode (
    .opcode  (opcode),
    .func    (func),
    .r_op    (r_op),
    .r_legal (r_legal),
    .i_op    (i_op),
    .i_legal (i_legal)
  );

  assign mem_done    = (MEM_WAIT_EN == 0) ? 1'b1 : mem_ready;
  assign mem_wait    = is_mem_state(state_q) && !mem_done;
  assign timeout_hit = mem_wait && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign is_jr       = (opcode == OP_RTYPE) && (func == FN_JR);
  assign is_jal      = (opcode == OP_JAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        wait_cnt <= '0;
      else if (mem_wait)
        wait_cnt <= wait_cnt + CNT_W'(1);
      if (state_d == S_TRAP)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_done)         state_d = S_DECODE;
        else if (timeout_hit) state_d = S_TRAP;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = is_jr ? S_JUMP : (r_legal ? S_EXEC_R : S_TRAP);
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J, OP_JAL:  state_d = S_JUMP;
          default:       state_d = i_legal ? S_EXEC_I : S_TRAP;
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_done)         state_d = S_WB_MEM;
        else if (timeout_hit) state_d = S_TRAP;
      end
      S_MEM_WR: begin
        if (mem_done)         state_d = S_FETCH;
        else if (timeout_hit) state_d = S_TRAP;
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // Outputs decode from the state register and are held low while reset is asserted
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    link       = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    op4        = ALU_NOP;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          op4       = ALU_ADD;
          ir_write  = mem_done;
          pc_write  = mem_done;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          op4       = ALU_ADD;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          op4       = r_op;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          op4       = i_op;
        end
        S_MEM_ADDR: begin
          alu_src_b = 2'b10;
          op4       = ALU_ADD;
        end
        S_MEM_RD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
        end
        S_MEM_WR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_WB_I:   reg_write = 1'b1;
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          pc_src    = 2'b01;
          op4       = ALU_SUB;
          pc_write  = zero ^ (opcode == OP_BNE);
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_src    = is_jr ? 2'b11 : 2'b10;
          reg_write = is_jal;
          link      = is_jal;
        end
        default: ;
      endcase
    end
  end

  assign alu_op  = ALUOP_W'(op4);
  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] func = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, ir_write, iord, mem_read, mem_write;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, link;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_op;
  logic       illegal;
  logic [3:0] state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .func       (func),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .link       (link),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .illegal    (illegal),
    .state      (state)
  );

  // Pulse reset in the low clock phase; the caller's cycle 0 is then FETCH
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'd0; func = 6'd0;
    @(negedge clk); #1;
    n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL reset_state got %0d expected 0", state); end
    n_cmp++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL reset_mem_read got %b expected 0", mem_read); end
    n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal got %b expected 0", illegal); end
    n_cmp++; if (pc_write !== 1'b0) begin n_err++; $display("FAIL reset_pc_write got %b expected 0", pc_write); end
    rst_n = 1'b1;
  endtask

  task automatic test_r_type();
    int exp_st[5];
    exp_st = '{0, 1, 2, 7, 0};
    do_reset();
    opcode = 6'b000000; func = 6'b100000; mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (state !== 4'(exp_st[k])) begin n_err++; $display("FAIL add_state k=%0d got %0d expected %0d", k, state, exp_st[k]); end
      n_cmp++; if (reg_write !== (k == 3)) begin n_err++; $display("FAIL add_reg_write k=%0d got %b expected %b", k, reg_write, k == 3); end
      if (k == 0) begin
        n_cmp++; if ({mem_read, ir_write, pc_write, alu_src_b, alu_op} !== {3'b111, 2'b01, 4'b0001}) begin n_err++; $display("FAIL fetch_ctrl got %b expected 111010001", {mem_read, ir_write, pc_write, alu_src_b, alu_op}); end
      end
      if (k == 1) begin
        n_cmp++; if ({alu_src_b, alu_op} !== 6'b110001) begin n_err++; $display("FAIL decode_ctrl got %b expected 110001", {alu_src_b, alu_op}); end
      end
      if (k == 2) begin
        n_cmp++; if ({alu_src_a, alu_src_b, alu_op} !== 7'b1000001) begin n_err++; $display("FAIL exec_r_ctrl got %b expected 1000001", {alu_src_a, alu_src_b, alu_op}); end
      end
      if (k == 3) begin
        n_cmp++; if (reg_dst !== 1'b1) begin n_err++; $display("FAIL wb_r_reg_dst got %b expected 1", reg_dst); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_i_type();
    int exp_st[5];
    exp_st = '{0, 1, 3, 8, 0};
    do_reset();
    opcode = 6'b001101; func = 6'b000000; mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (state !== 4'(exp_st[k])) begin n_err++; $display("FAIL ori_state k=%0d got %0d expected %0d", k, state, exp_st[k]); end
      if (k == 2) begin
        n_cmp++; if ({alu_src_a, alu_src_b, alu_op} !== 7'b1100100) begin n_err++; $display("FAIL exec_i_ctrl got %b expected 1100100", {alu_src_a, alu_src_b, alu_op}); end
      end
      if (k == 3) begin
        n_cmp++; if ({reg_write, reg_dst} !== 2'b10) begin n_err++; $display("FAIL wb_i_ctrl got %b expected 10", {reg_write, reg_dst}); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lw_wait();
    int exp_st[8];
    int rd_cnt;
    exp_st = '{0, 1, 4, 5, 5, 5, 5, 9};
    rd_cnt = 0;
    do_reset();
    opcode = 6'b100011;
    for (int k = 0; k < 8; k++) begin
      mem_ready = (k < 3) || (k >= 6);
      #1;
      n_cmp++; if (state !== 4'(exp_st[k])) begin n_err++; $display("FAIL lw_state k=%0d got %0d expected %0d", k, state, exp_st[k]); end
      n_cmp++; if (mem_read !== (k == 0 || (k >= 3 && k <= 6))) begin n_err++; $display("FAIL lw_mem_read k=%0d got %b", k, mem_read); end
      n_cmp++; if (reg_write !== (k == 7)) begin n_err++; $display("FAIL lw_reg_write k=%0d got %b", k, reg_write); end
      if (state == 4'd5 && mem_read === 1'b1) rd_cnt++;
      if (k == 7) begin
        n_cmp++; if (mem_to_reg !== 1'b1) begin n_err++; $display("FAIL wb_mem_to_reg got %b expected 1", mem_to_reg); end
      end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL lw_total_8 got state %0d expected 0", state); end
    n_cmp++; if (rd_cnt !== 4) begin n_err++; $display("FAIL lw_read_hold got %0d expected 4", rd_cnt); end
  endtask

  task automatic test_sw();
    int exp_st[5];
    exp_st = '{0, 1, 4, 6, 0};
    do_reset();
    opcode = 6'b101011; mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (state !== 4'(exp_st[k])) begin n_err++; $display("FAIL sw_state k=%0d got %0d expected %0d", k, state, exp_st[k]); end
      n_cmp++; if (mem_write !== (k == 3)) begin n_err++; $display("FAIL sw_mem_write k=%0d got %b", k, mem_write); end
      if (k == 2) begin
        n_cmp++; if ({alu_src_b, alu_op} !== 6'b100001) begin n_err++; $display("FAIL mem_addr_ctrl got %b expected 100001", {alu_src_b, alu_op}); end
      end
      if (k == 3) begin
        n_cmp++; if (iord !== 1'b1) begin n_err++; $display("FAIL sw_iord got %b expected 1", iord); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops[3];
    logic       zs[3];
    logic       exp_pw[3];
    ops = '{6'b000100, 6'b000101, 6'b000100};
    zs = '{1'b1, 1'b1, 1'b0};
    exp_pw = '{1'b1, 1'b0, 1'b0};
    for (int t = 0; t < 3; t++) begin
      do_reset();
      opcode = ops[t]; zero = zs[t]; mem_ready = 1'b1;
      @(negedge clk); @(negedge clk); #1;
      n_cmp++; if (state !== 4'd10) begin n_err++; $display("FAIL br_state t=%0d got %0d expected 10", t, state); end
      n_cmp++; if (pc_write !== exp_pw[t]) begin n_err++; $display("FAIL br_pc_write t=%0d got %b expected %b", t, pc_write, exp_pw[t]); end
      n_cmp++; if ({alu_src_a, pc_src, alu_op} !== 7'b1011010) begin n_err++; $display("FAIL br_ctrl t=%0d got %b expected 1011010", t, {alu_src_a, pc_src, alu_op}); end
      @(negedge clk); #1;
      n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL br_return t=%0d got %0d expected 0", t, state); end
    end
    zero = 1'b0;
  endtask

  task automatic test_jump();
    logic [5:0] ops[3];
    logic [5:0] fns[3];
    logic [3:0] exp_j[3];
    ops = '{6'b000010, 6'b000011, 6'b000000};
    fns = '{6'b000000, 6'b000000, 6'b001000};
    exp_j = '{4'b1100, 4'b1111, 4'b1100};
    for (int t = 0; t < 3; t++) begin
      do_reset();
      opcode = ops[t]; func = fns[t]; mem_ready = 1'b1;
      @(negedge clk); @(negedge clk); #1;
      n_cmp++; if (state !== 4'd11) begin n_err++; $display("FAIL jmp_state t=%0d got %0d expected 11", t, state); end
      n_cmp++; if ({pc_write, reg_write, link} !== {1'b1, exp_j[t][1:0]}) begin n_err++; $display("FAIL jmp_strobes t=%0d got %b expected %b", t, {pc_write, reg_write, link}, {1'b1, exp_j[t][1:0]}); end
      n_cmp++; if (pc_src !== ((t == 2) ? 2'b11 : 2'b10)) begin n_err++; $display("FAIL jmp_pc_src t=%0d got %b", t, pc_src); end
    end
    func = 6'd0;
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = 6'b111111; mem_ready = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (state !== 4'd1 || illegal !== 1'b0) begin n_err++; $display("FAIL ill_decode got state %0d illegal %b expected 1/0", state, illegal); end
    @(negedge clk); #1;
    n_cmp++; if (state !== 4'd12 || illegal !== 1'b1) begin n_err++; $display("FAIL ill_trap got state %0d illegal %b expected 12/1", state, illegal); end
    opcode = 6'b000000; func = 6'b100000;
    repeat (4) @(negedge clk);
    #1;
    n_cmp++; if (state !== 4'd12 || illegal !== 1'b1 || mem_read !== 1'b0) begin n_err++; $display("FAIL ill_sticky got state %0d illegal %b mem_read %b", state, illegal, mem_read); end
    do_reset();
    #1;
    n_cmp++; if (illegal !== 1'b0 || state !== 4'd0) begin n_err++; $display("FAIL ill_clear got illegal %b state %0d expected 0/0", illegal, state); end
  endtask

  task automatic test_timeout();
    do_reset();
    opcode = 6'b000000; func = 6'b100000; mem_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      n_cmp++; if (state !== ((k < 15) ? 4'd0 : 4'd12)) begin n_err++; $display("FAIL tmo_state k=%0d got %0d", k, state); end
      n_cmp++; if (illegal !== (k == 15)) begin n_err++; $display("FAIL tmo_illegal k=%0d got %b", k, illegal); end
      @(negedge clk);
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    opcode = 6'b101011; mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) mem_ready = 1'b0;
      @(negedge clk);
    end
    #1;
    n_cmp++; if (state !== 4'd6 || mem_write !== 1'b1) begin n_err++; $display("FAIL mwr_pre got state %0d mem_write %b expected 6/1", state, mem_write); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (mem_write !== 1'b0 || iord !== 1'b0) begin n_err++; $display("FAIL mwr_async_strobe got mem_write %b iord %b expected 0/0", mem_write, iord); end
    n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL mwr_async_state got %0d expected 0", state); end
    rst_n = 1'b1;
    mem_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_i_type();
    test_lw_wait();
    test_sw();
    test_branch();
    test_jump();
    test_illegal();
    test_timeout();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL provide parameter ALUOP_W, default 4, width of the alu_op output.
REQ-002 The block SHALL provide parameter MEM_WAIT_EN, default 1; 1 = stall on mem_ready, 0 = memory assumed single-cycle (mem_ready ignored).
REQ-003 The block SHALL provide parameter TIMEOUT, default 15, maximum wait cycles per memory access before TRAP.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 opcode  in  6  instruction[31:26], sampled from IR.
REQ-007 func  in  6  instruction[5:0].
REQ-008 zero  in  1  ALU zero flag.
REQ-009 mem_ready  in  1  memory access complete.
REQ-010 pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, link  out  1 each  datapath controls.
REQ-011 alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2.
REQ-012 pc_src  out  2  00 ALU result, 01 ALUOut (branch), 10 jump target, 11 rs (jr).
REQ-013 alu_op  out  ALUOP_W  ALU operation code.
REQ-014 illegal  out  1  sticky, unsupported opcode/func or memory timeout.
REQ-015 state  out  4  current state, debug.

Function
REQ-016 States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, TRAP; state register updates on rising clk.
REQ-017 FETCH: mem_read=1, iord=0, alu_src_b=01, alu_op=ADD; on (mem_ready or MEM_WAIT_EN=0) pulse ir_write and pc_write for exactly that cycle, then go to DECODE; otherwise remain.
REQ-018 DECODE (1 cycle): alu_src_b=11, alu_op=ADD (branch target); next: R-type->EXEC_R (func jr->JUMP), addi/addiu/andi/ori/slti/sltiu/lui->EXEC_I, lw/sw->MEM_ADDR, beq/bne->BRANCH, j/jal->JUMP, else TRAP.
REQ-019 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op from func table; next WB_R. WB_R: reg_write=1, reg_dst=1; next FETCH.
REQ-020 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op from opcode table; next WB_I. WB_I: reg_write=1, reg_dst=0; next FETCH.
REQ-021 MEM_ADDR: alu_src_b=10, alu_op=ADD; lw->MEM_RD, sw->MEM_WR.
REQ-022 MEM_RD/MEM_WR: iord=1, mem_read resp. mem_write held high until mem_ready; MEM_RD->WB_MEM, MEM_WR->FETCH. WB_MEM: reg_write=1, mem_to_reg=1.
REQ-023 BRANCH: alu_op=SUB, alu_src_a=1, pc_src=01; pc_write=1 combinationally iff (zero XOR bne); next FETCH.
REQ-024 JUMP: pc_write=1, pc_src=10 (j/jal) or 11 (jr); jal additionally reg_write=1, link=1 (write PC+4 to r31); next FETCH.
REQ-025 Memory wait counter increments each cycle mem_ready=0 during FETCH/MEM_RD/MEM_WR, clears on state change; reaching TIMEOUT -> TRAP.
REQ-026 TRAP: all strobes 0, illegal=1; held until reset.
REQ-027 Every output not listed for a state SHALL be 0; strobes never assert in two consecutive states except where listed.
REQ-028 Function codes: add 0001, addu 0010, and 0011, or 0100, nor 0101, sltu 0110, slt 0111, sll 1000, srl 1001, sub 1010, subu 1011, sra 1100, lui 1101; ALUOP_W>4 zero-extends.

Reset
REQ-029 rst_n low SHALL immediately force state=FETCH, wait counter=0, illegal=0, all registered outputs 0, including mid-access.
REQ-030 First FETCH after rst_n rises SHALL begin on the next rising clk.

Structure
REQ-031 State encoding, ALU op codes, opcode/func constants SHALL live in shared package mips_ctrl_pkg.
REQ-032 Opcode/func to alu_op decoding SHALL be a combinational sub-module alu_op_decode.

Verification
REQ-033 add r3,r1,r2 with mem_ready=1: FETCH,DECODE,EXEC_R,WB_R -> 4 cycles, alu_op=0001, reg_write only in WB_R.
REQ-034 lw with mem_ready delayed 3 cycles in MEM_RD -> mem_read held 4 cycles, total 8 cycles, mem_to_reg=1 in WB_MEM.
REQ-035 beq zero=1 -> pc_write=1, pc_src=01; bne zero=1 -> pc_write=0.
REQ-036 opcode 111111 -> TRAP after DECODE, illegal=1 sticky; mem_ready stuck 0 -> TRAP after 15 wait cycles.
REQ-037 rst_n dropped mid MEM_WR -> mem_write falls same cycle, state=FETCH asynchronously.
